// File: rtl/data_ctrl.sv
// data_ctrl: byte-serial memory controller between the reorder buffer (stores)
// and the load buffer (loads). One pending slot per requestor; stores win when
// both are pending. Stores write one byte per cycle; loads issue one address
// per cycle and capture returned bytes one cycle later, then extend the result.
module data_ctrl (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_rst_in,
   input  logic        rob_datactrl_en_in,
   input  logic [31:0] rob_datactrl_addr_in,
   input  logic [2:0]  rob_datactrl_width_in,
   input  logic [31:0] rob_datactrl_data_in,
   output logic        datactrl_rob_en_out,
   input  logic        lbuffer_datactrl_en_in,
   input  logic [31:0] lbuffer_datactrl_addr_in,
   input  logic [2:0]  lbuffer_datactrl_width_in,
   input  logic        lbuffer_datactrl_signed_in,
   output logic        datactrl_lbuffer_en_out,
   output logic [31:0] datactrl_lbuffer_data_out,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr
);

   typedef enum logic [2:0] {IDLE, STORE, LOAD, DONE_S, DONE_L} state_t;

   state_t      state;
   logic [1:0]  cnt;          // byte index of the memory cycle in progress
   logic [1:0]  cnt_inc;

   // pending request slots
   logic        st_pend;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_width;
   logic        ld_pend;
   logic [31:0] ld_addr;
   logic [2:0]  ld_width;
   logic        ld_sgn;

   // operation currently owning the memory port
   logic [31:0] op_addr;
   logic [31:0] op_data;
   logic [1:0]  op_last;      // index of final byte (n-1)
   logic [2:0]  op_width;
   logic        op_signed;

   // load capture: mem_din holds byte cap_idx whenever ld_cap is set
   logic        ld_cap;
   logic        ld_tail;      // all addresses issued, waiting for last byte
   logic [1:0]  cap_idx;
   logic [31:0] ld_buf;
   logic [31:0] ld_merge;

   logic        wr_q;
   logic        rob_en_q;
   logic        lb_en_q;
   logic        launch;

   function automatic logic width_ok(input logic [2:0] w);
      return (w == 3'b001) || (w == 3'b010) || (w == 3'b100);
   endfunction

   function automatic logic [1:0] last_idx(input logic [2:0] w);
      case (w)
         3'b001:  return 2'd0;
         3'b010:  return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] w,
                                          input logic s);
      case (w)
         3'b001:  return {{24{s & v[7]}}, v[7:0]};
         3'b010:  return {{16{s & v[15]}}, v[15:0]};
         default: return v;
      endcase
   endfunction

   // next byte index and the load word with the byte on mem_din folded in
   always_comb begin
      cnt_inc = cnt + 2'd1;
      ld_merge = ld_buf;
      ld_merge[{cap_idx, 3'b000} +: 8] = mem_din;
   end

   // states in which the port is free for the next operation (a flush frees an active load)
   always_comb begin
      launch = (state == IDLE) || (state == DONE_S) || (state == DONE_L) ||
               ((state == LOAD) && rob_rst_in);
   end

   // main FSM, slots and registered memory/response outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         st_pend   <= 1'b0;
         st_addr   <= '0;
         st_data   <= '0;
         st_width  <= '0;
         ld_pend   <= 1'b0;
         ld_addr   <= '0;
         ld_width  <= '0;
         ld_sgn    <= 1'b0;
         op_addr   <= '0;
         op_data   <= '0;
         op_last   <= 2'd0;
         op_width  <= '0;
         op_signed <= 1'b0;
         ld_cap    <= 1'b0;
         ld_tail   <= 1'b0;
         cap_idx   <= 2'd0;
         ld_buf    <= '0;
         wr_q      <= 1'b0;
         rob_en_q  <= 1'b0;
         lb_en_q   <= 1'b0;
         mem_a     <= '0;
         mem_dout  <= '0;
         datactrl_lbuffer_data_out <= '0;
      end else if (rdy_in) begin
         rob_en_q <= 1'b0;
         lb_en_q  <= 1'b0;

         case (state)
            STORE: begin
               if (cnt == op_last) begin
                  state    <= DONE_S;
                  wr_q     <= 1'b0;
                  rob_en_q <= 1'b1;
               end else begin
                  cnt      <= cnt_inc;
                  mem_a    <= op_addr + {30'd0, cnt_inc};
                  mem_dout <= op_data[{cnt_inc, 3'b000} +: 8];
               end
            end
            LOAD: begin
               if (!rob_rst_in) begin
                  if (ld_cap) ld_buf <= ld_merge;
                  if (ld_tail) begin
                     state   <= DONE_L;
                     lb_en_q <= 1'b1;
                     ld_cap  <= 1'b0;
                     ld_tail <= 1'b0;
                     datactrl_lbuffer_data_out <= extend(ld_merge, op_width, op_signed);
                  end else begin
                     ld_cap  <= 1'b1;
                     cap_idx <= cnt;
                     if (cnt == op_last) begin
                        ld_tail <= 1'b1;
                     end else begin
                        cnt   <= cnt_inc;
                        mem_a <= op_addr + {30'd0, cnt_inc};
                     end
                  end
               end
            end
            default: ;
         endcase

         if (launch) begin
            cnt     <= 2'd0;
            ld_cap  <= 1'b0;
            ld_tail <= 1'b0;
            if (st_pend) begin
               state    <= STORE;
               st_pend  <= 1'b0;
               op_addr  <= st_addr;
               op_data  <= st_data;
               op_last  <= last_idx(st_width);
               op_width <= st_width;
               wr_q     <= 1'b1;
               mem_a    <= st_addr;
               mem_dout <= st_data[7:0];
            end else if (ld_pend && !rob_rst_in) begin
               state     <= LOAD;
               ld_pend   <= 1'b0;
               op_addr   <= ld_addr;
               op_last   <= last_idx(ld_width);
               op_width  <= ld_width;
               op_signed <= ld_sgn;
               ld_buf    <= '0;
               wr_q      <= 1'b0;
               mem_a     <= ld_addr;
            end else begin
               state <= IDLE;
               wr_q  <= 1'b0;
            end
         end

         // a flush kills any queued load, including one arriving this cycle
         if (rob_rst_in) ld_pend <= 1'b0;

         if (rob_datactrl_en_in && width_ok(rob_datactrl_width_in)) begin
            st_pend  <= 1'b1;
            st_addr  <= rob_datactrl_addr_in;
            st_data  <= rob_datactrl_data_in;
            st_width <= rob_datactrl_width_in;
         end

         if (lbuffer_datactrl_en_in && width_ok(lbuffer_datactrl_width_in) && !rob_rst_in) begin
            ld_pend  <= 1'b1;
            ld_addr  <= lbuffer_datactrl_addr_in;
            ld_width <= lbuffer_datactrl_width_in;
            ld_sgn   <= lbuffer_datactrl_signed_in;
         end
      end
   end

   // a stalled cycle never writes and never counts as a completion pulse
   always_comb begin
      mem_wr                  = wr_q & rdy_in;
      datactrl_rob_en_out     = rob_en_q & rdy_in;
      datactrl_lbuffer_en_out = lb_en_q & rdy_in;
   end

endmodule

// File: tb/tb_data_ctrl.sv
// Directed bench for data_ctrl: expected memory writes and completion pulses
// are queued with their cycle numbers when a request is driven, and popped
// and compared as the DUT produces them. A byte memory model answers loads.
module tb_data_ctrl;
   localparam int K_WR = 0, K_ST = 1, K_LD = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } ev_t;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_rst_in;
   logic        rob_datactrl_en_in;
   logic [31:0] rob_datactrl_addr_in;
   logic [2:0]  rob_datactrl_width_in;
   logic [31:0] rob_datactrl_data_in;
   logic        datactrl_rob_en_out;
   logic        lbuffer_datactrl_en_in;
   logic [31:0] lbuffer_datactrl_addr_in;
   logic [2:0]  lbuffer_datactrl_width_in;
   logic        lbuffer_datactrl_signed_in;
   logic        datactrl_lbuffer_en_out;
   logic [31:0] datactrl_lbuffer_data_out;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   logic [7:0] mem [logic [31:0]];

   data_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_rst_in(rob_rst_in),
      .rob_datactrl_en_in(rob_datactrl_en_in), .rob_datactrl_addr_in(rob_datactrl_addr_in),
      .rob_datactrl_width_in(rob_datactrl_width_in), .rob_datactrl_data_in(rob_datactrl_data_in),
      .datactrl_rob_en_out(datactrl_rob_en_out),
      .lbuffer_datactrl_en_in(lbuffer_datactrl_en_in),
      .lbuffer_datactrl_addr_in(lbuffer_datactrl_addr_in),
      .lbuffer_datactrl_width_in(lbuffer_datactrl_width_in),
      .lbuffer_datactrl_signed_in(lbuffer_datactrl_signed_in),
      .datactrl_lbuffer_en_out(datactrl_lbuffer_en_out),
      .datactrl_lbuffer_data_out(datactrl_lbuffer_data_out),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // byte memory: read data appears the cycle after the address
   always @(posedge clk_in) begin
      if (rdy_in) begin
         mem_din <= mem_rd(mem_a);
         if (mem_wr) mem[mem_a] = mem_dout;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int k, input int c, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k; e.cyc = c; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic got(input int k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("extra_event_kind", k, 32'hFFFF_FFFF);
         return;
      end
      e = exp_q.pop_front();
      check($sformatf("kind@%0d", e.cyc), k, e.kind);
      check($sformatf("cycle_k%0d", k), cyc, e.cyc);
      if (k == K_WR) begin
         check($sformatf("wr_addr@%0d", e.cyc), a, e.addr);
         check($sformatf("wr_data@%0d", e.cyc), d, e.data);
      end else if (k == K_LD) begin
         check($sformatf("ld_data@%0d", e.cyc), d, e.data);
      end
   endtask

   task automatic monitor();
      if (rst_in !== 1'b1) return;
      if (exp_q.size() == 0) begin
         check("idle_no_activity", {29'd0, mem_wr, datactrl_rob_en_out, datactrl_lbuffer_en_out}, 0);
      end else begin
         if (mem_wr) got(K_WR, mem_a, {24'd0, mem_dout});
         if (datactrl_rob_en_out) got(K_ST, 0, 0);
         if (datactrl_lbuffer_en_out) got(K_LD, 0, datactrl_lbuffer_data_out);
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check($sformatf("missed_event_k%0d", exp_q[0].kind), cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   endtask

   // sample mid-cycle, then step to just after the next rising edge
   task automatic cycle_();
      @(negedge clk_in);
      monitor();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int nbytes(input logic [2:0] w);
      return (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
   endfunction

   task automatic drive_req(input bit st, input logic [31:0] sa, input logic [2:0] sw,
                            input logic [31:0] sd, input bit ld, input logic [31:0] la,
                            input logic [2:0] lw, input bit ls, output int t0);
      rob_datactrl_en_in         = st;
      rob_datactrl_addr_in       = sa;
      rob_datactrl_width_in      = sw;
      rob_datactrl_data_in       = sd;
      lbuffer_datactrl_en_in     = ld;
      lbuffer_datactrl_addr_in   = la;
      lbuffer_datactrl_width_in  = lw;
      lbuffer_datactrl_signed_in = ls;
      t0 = cyc + 1;
      cycle_();
      rob_datactrl_en_in     = 1'b0;
      lbuffer_datactrl_en_in = 1'b0;
   endtask

   // writes in cycles first..first+n-1, completion pulse right after
   task automatic exp_store(input int first, input logic [31:0] a, input logic [2:0] w,
                            input logic [31:0] d);
      logic [31:0] dv;
      dv = d;
      for (int i = 0; i < nbytes(w); i++)
         push_ev(K_WR, first + i, a + i, {24'd0, dv[8*i +: 8]});
      push_ev(K_ST, first + nbytes(w), 0, 0);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         cycle_();
         k++;
      end
      check("drain_before_timeout", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) cycle_();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
      int t0;
      drive_req(1'b1, a, w, d, 1'b0, 0, 3'b000, 1'b0, t0);
      exp_store(t0 + 1, a, w, d);
      wait_idle(40);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] w, input bit s,
                          input logic [31:0] exp);
      int t0;
      drive_req(1'b0, 0, 3'b000, 0, 1'b1, a, w, s, t0);
      push_ev(K_LD, t0 + nbytes(w) + 2, 0, exp);
      wait_idle(40);
   endtask

   initial begin
      int t0;
      rst_in = 1'b0; rdy_in = 1'b1; rob_rst_in = 1'b0;
      rob_datactrl_en_in = 1'b0; rob_datactrl_addr_in = '0;
      rob_datactrl_width_in = '0; rob_datactrl_data_in = '0;
      lbuffer_datactrl_en_in = 1'b0; lbuffer_datactrl_addr_in = '0;
      lbuffer_datactrl_width_in = '0; lbuffer_datactrl_signed_in = 1'b0;
      repeat (2) cycle_();
      check("rst_mem_wr", {31'd0, mem_wr}, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_dout", {24'd0, mem_dout}, 0);
      check("rst_rob_en", {31'd0, datactrl_rob_en_out}, 0);
      check("rst_lb_en", {31'd0, datactrl_lbuffer_en_out}, 0);
      check("rst_data_out", datactrl_lbuffer_data_out, 0);
      rst_in = 1'b1;
      repeat (2) cycle_();

      // word store, then byte/half/word stores used as load data
      do_store(32'h100, 3'b100, 32'hDEAD_BEEF);
      do_store(32'h20, 3'b001, 32'h0000_0080);
      do_store(32'h30, 3'b010, 32'h0000_1234);
      do_store(32'h34, 3'b010, 32'h0000_8001);
      do_store(32'h50, 3'b100, 32'h4433_2211);

      // loads with each width and extension mode
      do_load(32'h20, 3'b001, 1'b1, 32'hFFFF_FF80);
      do_load(32'h20, 3'b001, 1'b0, 32'h0000_0080);
      do_load(32'h30, 3'b010, 1'b0, 32'h0000_1234);
      do_load(32'h34, 3'b010, 1'b1, 32'hFFFF_8001);
      do_load(32'h34, 3'b010, 1'b0, 32'h0000_8001);
      do_load(32'h100, 3'b001, 1'b1, 32'hFFFF_FFEF);
      do_load(32'h50, 3'b100, 1'b1, 32'h4433_2211);

      // store and load together: store owns the port first
      drive_req(1'b1, 32'h40, 3'b001, 32'h55, 1'b1, 32'h40, 3'b001, 1'b0, t0);
      exp_store(t0 + 1, 32'h40, 3'b001, 32'h55);
      push_ev(K_LD, t0 + 5, 0, 32'h0000_0055);
      wait_idle(40);

      // flush during an in-flight word load: no result, later store normal
      drive_req(1'b0, 0, 3'b000, 0, 1'b1, 32'h50, 3'b100, 1'b0, t0);
      repeat (2) cycle_();
      rob_rst_in = 1'b1;
      cycle_();
      rob_rst_in = 1'b0;
      repeat (8) cycle_();
      do_store(32'h60, 3'b001, 32'h0000_00A5);

      // three stalled cycles in the middle of a halfword store
      drive_req(1'b1, 32'h70, 3'b010, 32'h0000_BEEF, 1'b0, 0, 3'b000, 1'b0, t0);
      push_ev(K_WR, t0 + 1, 32'h70, 32'hEF);
      push_ev(K_WR, t0 + 5, 32'h71, 32'hBE);
      push_ev(K_ST, t0 + 6, 0, 0);
      repeat (2) cycle_();
      rdy_in = 1'b0;
      repeat (3) cycle_();
      rdy_in = 1'b1;
      wait_idle(40);

      // address wrap at the top of the space
      do_store(32'hFFFF_FFFF, 3'b010, 32'h0000_5678);
      do_load(32'hFFFF_FFFF, 3'b010, 1'b0, 32'h0000_5678);

      // unsupported widths are dropped
      drive_req(1'b1, 32'h80, 3'b011, 32'h1, 1'b1, 32'h20, 3'b111, 1'b0, t0);
      repeat (8) cycle_();

      // load arriving together with a flush is discarded
      rob_rst_in = 1'b1;
      drive_req(1'b0, 0, 3'b000, 0, 1'b1, 32'h20, 3'b001, 1'b0, t0);
      rob_rst_in = 1'b0;
      repeat (8) cycle_();

      // reset during a word store: byte 0 goes out, then everything clears
      drive_req(1'b1, 32'h200, 3'b100, 32'h1122_3344, 1'b0, 0, 3'b000, 1'b0, t0);
      push_ev(K_WR, t0 + 1, 32'h200, 32'h44);
      repeat (2) cycle_();
      rst_in = 1'b0;
      #1;
      check("mid_rst_mem_wr", {31'd0, mem_wr}, 0);
      check("mid_rst_mem_a", mem_a, 0);
      check("mid_rst_mem_dout", {24'd0, mem_dout}, 0);
      check("mid_rst_rob_en", {31'd0, datactrl_rob_en_out}, 0);
      check("mid_rst_data_out", datactrl_lbuffer_data_out, 0);
      check("mid_rst_queue", exp_q.size(), 0);
      repeat (2) cycle_();
      rst_in = 1'b1;
      repeat (6) cycle_();
      do_store(32'h210, 3'b001, 32'h0000_0077);
      do_load(32'h210, 3'b001, 1'b0, 32'h0000_0077);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/data_ctrl.md
DATA_CTRL -- requirements
Module: data_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have rst_in  in  1  asynchronous active-low reset, clears all state immediately when 0.
REQ-003 SHALL have rdy_in  in  1  global ready; 0 freezes all state.
REQ-004 SHALL have rob_rst_in  in  1  speculation flush from reorder buffer.
REQ-005 SHALL have store request inputs: rob_datactrl_en_in 1, rob_datactrl_addr_in 32, rob_datactrl_width_in 3 (001=B, 010=H, 100=W), rob_datactrl_data_in 32.
REQ-006 SHALL have datactrl_rob_en_out  out  1  store-complete pulse.
REQ-007 SHALL have load request inputs: lbuffer_datactrl_en_in 1, lbuffer_datactrl_addr_in 32, lbuffer_datactrl_width_in 3, lbuffer_datactrl_signed_in 1.
REQ-008 SHALL have datactrl_lbuffer_en_out  out  1 (load-result pulse) and datactrl_lbuffer_data_out  out  32 (extended load data).
REQ-009 SHALL have memory port: mem_din  in  8, mem_dout  out  8, mem_a  out  32, mem_wr  out  1 (1=write).

Function
REQ-010 Each en_in SHALL be treated as a one-cycle request; request latched when en_in=1 at a rising edge with rdy_in=1 (that cycle = cycle 0).
REQ-011 SHALL hold one pending store slot and one pending load slot; a request arriving while busy SHALL be latched in its slot; requestor guarantees at most one outstanding per port.
REQ-012 FSM states: IDLE, STORE, LOAD, DONE_S, DONE_L; byte counter 2 bits, n = width in bytes.
REQ-013 IDLE: if store pending -> STORE; else if load pending -> LOAD; store SHALL win when both pending.
REQ-014 STORE: in cycles 1..n after start, mem_wr=1, mem_a=addr+i, mem_dout=data[8i+7:8i], i=0..n-1 little-endian; then DONE_S.
REQ-015 DONE_S: datactrl_rob_en_out=1 for exactly one cycle (cycle n+1), mem_wr=0, then IDLE.
REQ-016 LOAD: mem_wr=0, mem_a=addr+i in cycle 1+i; mem_din carries byte i in cycle 2+i and SHALL be sampled then; then DONE_L.
REQ-017 DONE_L: datactrl_lbuffer_en_out=1 for exactly one cycle (cycle n+2) with data_out valid that cycle.
REQ-018 Load extension: width 001/010 SHALL sign-extend bit 7/15 when signed_in=1, else zero-extend; width 100 passes 32 bits.
REQ-019 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 wraps to 0).
REQ-020 Next operation's first memory cycle SHALL be the cycle after the DONE pulse; no overlap of store and load memory cycles.
REQ-021 mem_wr SHALL be 0 in every state other than STORE and whenever rdy_in=0.
REQ-022 rdy_in=0: counter, FSM, slots, outputs frozen; requests not latched; memory sampling suspended and resumed identically.
REQ-023 rob_rst_in=1: abort in-flight load and clear pending load slot, no result pulse, return to IDLE (or STORE if store pending); in-flight and pending stores SHALL complete unaffected.
REQ-024 Load request arriving in same cycle as rob_rst_in SHALL be discarded.
REQ-025 Widths other than 001/010/100 SHALL be ignored (request dropped, no pulse).

Reset
REQ-026 rst_in=0 SHALL asynchronously force: FSM=IDLE, slots empty, counter 0, mem_wr=0, mem_a=0, mem_dout=0, both en_out=0, data_out=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no completion pulse; first request after rst_in returns 1 proceeds normally.

Verification
REQ-028 SW addr 0x100 data 0xDEADBEEF -> writes EF,BE,AD,DE to 0x100..0x103 in cycles 1-4, rob done pulse cycle 5.
REQ-029 LB signed addr 0x20, mem byte 0x80 -> data_out 0xFFFFFF80 pulse cycle 3; LHU bytes 0x34,0x12 -> 0x00001234 pulse cycle 4.
REQ-030 Store and load (SB 0x40=0x55, LBU 0x40) same cycle -> store first, load returns 0x00000055.
REQ-031 LW in flight, rob_rst_in at cycle 2 -> no load pulse, mem_wr stays 0; subsequent SB completes with pulse at expected cycle.
REQ-032 rdy_in=0 for 3 cycles during SH -> write sequence stretched by 3 cycles, byte order/addresses unchanged, single done pulse.
REQ-033 rst_in low during SW byte 2 -> mem_wr drops immediately, no done pulse, all outputs 0.
